// File: rtl/gelu_lut_interp.sv
// Streaming GELU evaluator: 3-stage valid/ready pipeline around a dual-port erf ROM.
// Define GELU_LUT_INTERP_EN for linear interpolation; otherwise nearest-lower sample only.
module gelu_lut_interp #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FRAC_BITS      = 12,
  parameter int unsigned LUT_ADDR_WIDTH = 7,
  parameter int unsigned LUT_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      lut_en,
  output logic [LUT_ADDR_WIDTH-1:0] lut_addr_a,
  output logic [LUT_ADDR_WIDTH-1:0] lut_addr_b,
  input  logic [LUT_DATA_WIDTH-1:0] lut_q_a,
  input  logic [LUT_DATA_WIDTH-1:0] lut_q_b
);

  localparam int unsigned E_W          = LUT_DATA_WIDTH - 1;
  localparam int unsigned M_W          = DATA_WIDTH + 1;
  localparam int unsigned PROD_W       = DATA_WIDTH + M_W;
  localparam int unsigned F_W          = 8;
  localparam int unsigned FINE_SHIFT   = FRAC_BITS - 5;  // 1/32 sample spacing below 2.0
  localparam int unsigned COARSE_SHIFT = FRAC_BITS - 4;  // 1/16 sample spacing in [2.0, 4.0)
  localparam logic [DATA_WIDTH-1:0]     COARSE_MAG  = DATA_WIDTH'(2 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0]     SAT_MAG     = DATA_WIDTH'(4 << FRAC_BITS);
  localparam logic [LUT_ADDR_WIDTH-1:0] COARSE_BASE = LUT_ADDR_WIDTH'(63);
  localparam logic [LUT_ADDR_WIDTH-1:0] ADDR_ONE    = LUT_ADDR_WIDTH'(1);
  localparam logic [M_W-1:0]            M_HALF      = M_W'(1 << (DATA_WIDTH - 1));
`ifdef GELU_LUT_INTERP_EN
  localparam int unsigned WIDE_W       = LUT_DATA_WIDTH + F_W;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic                  sign;
    logic                  sat;
    logic                  lo_zero;
`ifdef GELU_LUT_INTERP_EN
    logic [F_W-1:0]        f;
`endif
  } stage_t;

  logic                      advance;
  logic                      s1_valid;
  logic                      s2_valid;
  stage_t                    s1;
  stage_t                    s2;
  stage_t                    s1_d;
  logic [DATA_WIDTH-1:0]     mag;
  logic [LUT_ADDR_WIDTH-1:0] fine_idx;
  logic [LUT_ADDR_WIDTH-1:0] addr_a_q;
  logic [LUT_ADDR_WIDTH-1:0] addr_a_d;
`ifdef GELU_LUT_INTERP_EN
  logic [LUT_ADDR_WIDTH-1:0] addr_b_q;
  logic [LUT_ADDR_WIDTH-1:0] addr_b_d;
  logic [LUT_DATA_WIDTH-1:0] span;
  logic [LUT_DATA_WIDTH-1:0] step;
`else
  logic                      unused_q_b;
`endif
  logic [LUT_DATA_WIDTH-1:0] lo;
  logic [E_W-1:0]            e;
  logic [M_W-1:0]            m;
  logic signed [PROD_W-1:0]  xs;
  logic signed [PROD_W-1:0]  ms;
  logic signed [PROD_W-1:0]  prod;
  logic [DATA_WIDTH-1:0]     out_c;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign lut_en   = s1_valid && advance;

  assign lut_addr_a = addr_a_q;
`ifdef GELU_LUT_INTERP_EN
  assign lut_addr_b = addr_b_q;
`else
  assign lut_addr_b = '0;
  assign unused_q_b = ^lut_q_b;
`endif

  // Magnitude as unsigned, so the most negative operand maps to 0x8000 and saturates.
  assign mag      = in_data[DATA_WIDTH-1] ? -in_data : in_data;
  assign fine_idx = LUT_ADDR_WIDTH'(mag >> FINE_SHIFT);

  // Operand classification and table addressing for the incoming operand.
  always_comb begin
    s1_d         = '0;
    addr_a_d     = '0;
`ifdef GELU_LUT_INTERP_EN
    addr_b_d     = '0;
`endif
    s1_d.x       = in_data;
    s1_d.sign    = in_data[DATA_WIDTH-1];
    if (mag >= SAT_MAG) begin
      s1_d.sat = 1'b1;
    end else if (mag < COARSE_MAG) begin
      // Sample k sits at (k+1)/32, so the lower neighbour is one below the segment index.
      addr_a_d     = fine_idx - ADDR_ONE;
      s1_d.lo_zero = (fine_idx == '0);
`ifdef GELU_LUT_INTERP_EN
      addr_b_d     = fine_idx;
      s1_d.f       = F_W'(mag << 1);
`endif
    end else begin
      addr_a_d = COARSE_BASE + LUT_ADDR_WIDTH'((mag - COARSE_MAG) >> COARSE_SHIFT);
`ifdef GELU_LUT_INTERP_EN
      addr_b_d = addr_a_d + ADDR_ONE;
      s1_d.f   = F_W'(mag);
`endif
    end
  end

  // Erf estimate from the ROM words, then y = x * (0.5 + 0.5*erf) in Q1.16 scaling.
  always_comb begin
    lo    = s2.lo_zero ? '0 : lut_q_a;
`ifdef GELU_LUT_INTERP_EN
    span  = LUT_DATA_WIDTH'(lut_q_b - lo);
    step  = LUT_DATA_WIDTH'((WIDE_W'(span) * WIDE_W'(s2.f)) >> F_W);
    e     = E_W'(lo + step);
`else
    e     = E_W'(lo);
`endif
    if (s2.sat) begin
      e = '1;
    end
    m     = s2.sign ? M_HALF - M_W'(e) : M_HALF + M_W'(e);
    xs    = {{(PROD_W - DATA_WIDTH){s2.x[DATA_WIDTH-1]}}, s2.x};
    ms    = {{(PROD_W - M_W){1'b0}}, m};
    prod  = xs * ms;
    out_c = DATA_WIDTH'(prod >>> DATA_WIDTH);
  end

  // Pipeline registers; everything holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      s1        <= '0;
      s2        <= '0;
      addr_a_q  <= '0;
`ifdef GELU_LUT_INTERP_EN
      addr_b_q  <= '0;
`endif
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (in_valid) begin
        s1       <= s1_d;
        addr_a_q <= addr_a_d;
`ifdef GELU_LUT_INTERP_EN
        addr_b_q <= addr_b_d;
`endif
      end
      if (s1_valid) begin
        s2 <= s1;
      end
      if (s2_valid) begin
        out_data <= out_c;
      end
    end
  end

endmodule

// File: tb/tb_gelu_lut_interp.sv
// Self-checking bench for gelu_lut_interp with a behavioural registered erf ROM.
// Expected results come from a reference model built on the same table contents.
module tb_gelu_lut_interp;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        lut_en;
  logic [6:0]  lut_addr_a;
  logic [6:0]  lut_addr_b;
  logic [15:0] lut_q_a;
  logic [15:0] lut_q_b;

  logic [15:0] rom [128];
  logic [15:0] sb_q [$];
  int          n_checks;
  int          n_fail;

  gelu_lut_interp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lut_en     (lut_en),
    .lut_addr_a (lut_addr_a),
    .lut_addr_b (lut_addr_b),
    .lut_q_a    (lut_q_a),
    .lut_q_b    (lut_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: outputs update only on enabled reads.
  always @(posedge clk) begin
    if (lut_en) begin
      lut_q_a <= rom[lut_addr_a];
      lut_q_b <= rom[lut_addr_b];
    end
  end

  // Positive-term series, no cancellation over the table range.
  function automatic real erf_fn(input real z);
    real sum, term;
    term = z;
    sum  = z;
    for (int n = 1; n < 200; n++) begin
      term = term * 2.0 * z * z / real'(2 * n + 1);
      sum  = sum + term;
    end
    return 2.0 / $sqrt(3.141592653589793) * $exp(-z * z) * sum;
  endfunction

  function automatic logic [15:0] gelu_ref(input logic [15:0] x);
    int a, lo, hi, f, e, m, idx;
    longint p;
    a  = x[15] ? 65536 - int'(x) : int'(x);
    lo = 0; hi = 0; f = 0;
    if (a < 8192) begin
      idx = a / 128;
      f   = (a % 128) * 2;
      lo  = (idx == 0) ? 0 : int'(rom[idx - 1]);
      hi  = int'(rom[idx]);
    end else if (a < 16384) begin
      idx = (a - 8192) / 256;
      f   = a % 256;
      lo  = int'(rom[63 + idx]);
      hi  = int'(rom[64 + idx]);
    end
`ifdef GELU_LUT_INTERP_EN
    e = lo + ((hi - lo) * f) / 256;
`else
    e = lo + 0 * (hi + f);
`endif
    if (a >= 16384) e = 32767;
    m = x[15] ? 32768 - e : 32768 + e;
    p = longint'($signed(x)) * longint'(m);
    return 16'(p >>> 16);
  endfunction

  function automatic logic [15:0] rand_x();
    logic [15:0] v;
    v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16383));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_checks++; if (lut_en !== 1'b0) begin n_fail++; $display("FAIL reset_lut_en: got %b want 0", lut_en); end
    n_checks++; if (lut_addr_a !== 7'd0) begin n_fail++; $display("FAIL reset_addr_a: got %0d want 0", lut_addr_a); end
    n_checks++; if (lut_addr_b !== 7'd0) begin n_fail++; $display("FAIL reset_addr_b: got %0d want 0", lut_addr_b); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  // Single operands with known results, latency and table addresses.
  task automatic test_values();
    logic [15:0] tx [7];
    logic [15:0] texp [7];
    int          ea [7];
    int          eb [7];
    int          lat;
    bit          seen;
    tx   = '{16'h1000, 16'hF000, 16'h1040, 16'h0040, 16'h2000, 16'h4000, 16'hB000};
`ifdef GELU_LUT_INTERP_EN
    texp = '{16'h0D76, 16'hFD76, 16'h0DBB, 16'h0020, 16'h1F45, 16'h3FFF, 16'hFFFF};
    eb   = '{32, 32, 32, 0, 64, -1, -1};
`else
    texp = '{16'h0D76, 16'hFD76, 16'h0DAB, 16'h0020, 16'h1F45, 16'h3FFF, 16'hFFFF};
    eb   = '{0, 0, 0, 0, 0, -1, -1};
`endif
    ea   = '{31, 31, 31, -1, 63, -1, -1};
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_data = tx[k]; out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL val_in_ready x=%h: got %b want 1", tx[k], in_ready); end
      @(posedge clk); #1; in_valid = 1'b0;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 10) begin
        @(negedge clk); lat++;
        if (lat == 1) begin
          n_checks++; if (lut_en !== 1'b1) begin n_fail++; $display("FAIL val_lut_en x=%h: got %b want 1", tx[k], lut_en); end
          if (ea[k] >= 0) begin
            n_checks++; if (int'(lut_addr_a) != ea[k]) begin n_fail++; $display("FAIL val_addr_a x=%h: got %0d want %0d", tx[k], lut_addr_a, ea[k]); end
          end
          if (eb[k] >= 0) begin
            n_checks++; if (int'(lut_addr_b) != eb[k]) begin n_fail++; $display("FAIL val_addr_b x=%h: got %0d want %0d", tx[k], lut_addr_b, eb[k]); end
          end
        end
        if (out_valid === 1'b1) seen = 1'b1;
      end
      n_checks++; if (!seen || lat != 3) begin n_fail++; $display("FAIL val_latency x=%h: got %0d cycles want 3", tx[k], lat); end
      n_checks++; if (out_data !== texp[k]) begin n_fail++; $display("FAIL val_result x=%h: got %h want %h", tx[k], out_data, texp[k]); end
      @(posedge clk); #1;
    end
  endtask

  // Full-rate stream of random operands checked against the reference model.
  task automatic test_back_to_back();
    int          sent, got, cyc, not_ready;
    logic [15:0] x, want;
    sent = 0; got = 0; cyc = 0; not_ready = 0;
    sb_q.delete();
    x = rand_x();
    while ((sent < 40 || sb_q.size() != 0) && cyc < 200) begin
      in_valid = (sent < 40); in_data = x; out_ready = 1'b1;
      @(negedge clk);
      if (in_ready !== 1'b1) not_ready++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got %h want no output", out_data); end
        else begin
          want = sb_q.pop_front();
          if (out_data !== want) begin n_fail++; $display("FAIL b2b_result #%0d: got %h want %h", got, out_data, want); end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin sb_q.push_back(gelu_ref(x)); sent++; x = rand_x(); end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (got != 40) begin n_fail++; $display("FAIL b2b_count: got %0d want 40", got); end
    n_checks++; if (cyc != 43) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 43", cyc); end
    n_checks++; if (not_ready != 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d low cycles want 0", not_ready); end
  endtask

  // Five-cycle output stall in the middle of an 8-operand stream.
  task automatic test_backpressure();
    int          sent, got, cyc;
    bit          stall;
    logic [15:0] x, want;
    sent = 0; got = 0; cyc = 0;
    sb_q.delete();
    x = rand_x();
    while ((sent < 8 || sb_q.size() != 0) && cyc < 100) begin
      stall = (cyc >= 5 && cyc < 10);
      in_valid = (sent < 8); in_data = x; out_ready = !stall;
      @(negedge clk);
      if (stall) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d: got %b want 0", cyc, in_ready); end
        n_checks++; if (lut_en !== 1'b0) begin n_fail++; $display("FAIL bp_lut_en cyc=%0d: got %b want 0", cyc, lut_en); end
        n_checks++;
        if (out_valid !== 1'b1 || sb_q.size() == 0 || out_data !== sb_q[0]) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d: got valid=%b data=%h want held head result", cyc, out_valid, out_data);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h want no output", out_data); end
        else begin
          want = sb_q.pop_front();
          if (out_data !== want) begin n_fail++; $display("FAIL bp_result #%0d: got %h want %h", got, out_data, want); end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin sb_q.push_back(gelu_ref(x)); sent++; x = rand_x(); end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d pending want 0", sb_q.size()); end
  endtask

  // Reset with three operands in flight, then one clean operand.
  task automatic test_reset_mid();
    int  stale, lat;
    bit  seen;
    sb_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 16'h0800 + 16'(k * 16'h0100);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d outputs want 0", stale); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h1000;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk); lat++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen || lat != 3) begin n_fail++; $display("FAIL rstmid_latency: got %0d cycles want 3", lat); end
    n_checks++; if (out_data !== 16'h0D76) begin n_fail++; $display("FAIL rstmid_result: got %h want 0d76", out_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    lut_q_a = '0; lut_q_b = '0;
    for (int k = 0; k < 128; k++) begin
      real t;
      if (k < 64) t = real'(k + 1) / 32.0;
      else        t = 2.0 + real'(k - 63) / 16.0;
      rom[k] = (k < 96) ? 16'($rtoi(32767.0 * erf_fn(t / $sqrt(2.0)) + 0.5)) : 16'h0000;
    end
    test_reset();
    test_values();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
